bp_table_scheduler: RTL
=======================

// Module: bp_table_scheduler
// PURPOSE
//  Owns a bimodal table of 2-bit saturating branch counters and shares its single access
//  slot between the fetch-side lookup port and the execute-side resolve (update) port.
//  Resolves are queued in a small FIFO and drained in idle cycles, or forced ahead of
//  lookups when the FIFO is full or the starvation limit is hit. Sits between fetch and
//  branch-resolution logic; prediction = counter MSB.
// PARAMETERS
//  IDX_W      4     table index width; table has 2**IDX_W entries
//  FIFO_DEPTH 4     resolve queue entries (power of 2, >=2)
//  MAX_DEFER  3     max consecutive cycles a non-empty queue may lose to lookups
//  INIT_CTR   2'b01 counter value of every entry after reset (weakly not-taken)
// PORTS
//  clk         in   1                 rising-edge clock
//  rst_n       in   1                 synchronous active-low reset
//  lk_valid    in   1                 lookup request
//  lk_idx      in   IDX_W             lookup table index
//  lk_ready    out  1                 lookup granted this cycle (combinational)
//  pred_valid  out  1                 prediction available (one cycle after grant)
//  pred_idx    out  IDX_W             index of that prediction
//  pred_taken  out  1                 predicted direction (counter[1])
//  rs_valid    in   1                 resolved-branch update request
//  rs_idx      in   IDX_W             index to update
//  rs_taken    in   1                 actual outcome
//  rs_ready    out  1                 queue can accept update (count < FIFO_DEPTH)
//  q_count     out  $clog2(FIFO_DEPTH)+1  current queue occupancy
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): all entries <= INIT_CTR; queue flushed (q_count=0); defer
//   counter=0; pred_valid=0, pred_idx=0, pred_taken=0. lk_ready=0 and rs_ready=0 while
//   rst_n=0. Reset mid-operation discards queued updates and any in-flight prediction.
//  Enqueue: rs_valid && rs_ready pushes {rs_idx,rs_taken} at posedge. rs_ready from
//   registered q_count only (no same-cycle pop credit).
//  Slot arbitration each cycle (one table access per cycle), priority order:
//   1 FORCE_DRAIN: q_count==FIFO_DEPTH, or q_count>0 && defer==MAX_DEFER -> pop head,
//     update entry; lk_ready=0.
//   2 LOOKUP: lk_valid -> lk_ready=1, read table[lk_idx]; if q_count>0, defer += 1.
//   3 IDLE_DRAIN: q_count>0 -> pop head, update entry.
//   4 none: no access.
//  defer resets to 0 on any pop and whenever q_count==0; saturates at MAX_DEFER.
//  Lookup latency 1: grant at cycle N -> pred_valid=1, pred_idx, pred_taken=table MSB at
//   cycle N+1; pred_valid=0 in cycles following no grant. No forwarding from queued
//   updates: lookup sees table state at grant cycle only.
//  Update: taken -> ctr+1 saturating at 2'b11; not taken -> ctr-1 saturating at 2'b00.
//   Written at posedge of the drain cycle; visible to lookups granted the next cycle.
//  Simultaneous push+pop: q_count unchanged; FIFO order strictly preserved; pointers wrap
//   modulo FIFO_DEPTH. Multiple queued updates to one index apply in order.
//  Requester must hold lk_valid/lk_idx until lk_ready; rs_valid/rs_idx/rs_taken until rs_ready.
// TESTING
//  T1 reset, lookup idx 5 -> next cycle pred_valid=1, pred_idx=5, pred_taken=0 (INIT 01).
//  T2 two rs taken idx 5 with lk_valid low -> drained in 2 idle cycles; then lookup 5 ->
//     pred_taken=1; ctr=11; a third taken leaves ctr=11 (saturate).
//  T3 lk_valid held high every cycle, one rs queued -> lookups granted 3 cycles, 4th cycle
//     lk_ready=0 and pop occurs, defer back to 0.
//  T4 lk_valid high, push 4 rs back-to-back -> q_count reaches 4, rs_ready=0, next cycle
//     forced drain with lk_ready=0; q_count=3, rs_ready=1.
//  T5 4 not-taken updates to idx 2 from INIT -> ctr=00 after 1 (saturate), pred_taken=0;
//     wrap check: push/pop >8 entries, order preserved.
//  T6 rst_n=0 with q_count=3 and pred pending -> q_count=0, pred_valid=0, all entries 01.

Source files
------------

// File: rtl/bp_table_scheduler_if.sv
// Lookup/prediction and resolve/queue signals between fetch/execute logic and the
// branch predictor table scheduler.
interface bp_table_scheduler_if #(
  parameter int IDX_W      = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             lk_valid;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_ready;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_taken;
  logic             rs_valid;
  logic [IDX_W-1:0] rs_idx;
  logic             rs_taken;
  logic             rs_ready;
  logic [CNT_W-1:0] q_count;

  modport master (
    output lk_valid, lk_idx, rs_valid, rs_idx, rs_taken,
    input  lk_ready, pred_valid, pred_idx, pred_taken, rs_ready, q_count
  );

  modport slave (
    input  lk_valid, lk_idx, rs_valid, rs_idx, rs_taken,
    output lk_ready, pred_valid, pred_idx, pred_taken, rs_ready, q_count
  );
endinterface

// File: rtl/bp_table_scheduler.sv
// Bimodal 2-bit counter table with one access slot per cycle, shared between fetch
// lookups and a queued stream of resolve updates (starvation-bounded drain).
module bp_table_scheduler #(
  parameter int         IDX_W      = 4,
  parameter int         FIFO_DEPTH = 4,
  parameter int         MAX_DEFER  = 3,
  parameter logic [1:0] INIT_CTR   = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  bp_table_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);
  localparam int N_ENT = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [DEF_W-1:0] DEF_MAX  = DEF_W'(MAX_DEFER);

  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_LOOKUP,
    SLOT_IDLE_DRAIN,
    SLOT_FORCE_DRAIN
  } slot_t;

  logic [1:0]       tbl      [N_ENT];
  logic [IDX_W-1:0] fifo_idx [FIFO_DEPTH];
  logic             fifo_tkn [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [DEF_W-1:0] defer;
  logic             pred_valid_q;
  logic [IDX_W-1:0] pred_idx_q;
  logic             pred_taken_q;

  slot_t            slot;
  logic             push;
  logic             pop;
  logic             lk_grant;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic [1:0]       head_ctr;
  logic [1:0]       new_ctr;

  always_comb begin
    slot = SLOT_NONE;
    if (!rst_n) begin
      slot = SLOT_NONE;
    end else if (count == CNT_FULL || (count != '0 && defer == DEF_MAX)) begin
      slot = SLOT_FORCE_DRAIN;
    end else if (bus.lk_valid) begin
      slot = SLOT_LOOKUP;
    end else if (count != '0) begin
      slot = SLOT_IDLE_DRAIN;
    end
  end

  assign lk_grant = (slot == SLOT_LOOKUP);
  assign pop      = (slot == SLOT_FORCE_DRAIN) || (slot == SLOT_IDLE_DRAIN);
  assign push     = bus.rs_valid && bus.rs_ready;

  assign bus.lk_ready   = lk_grant;
  assign bus.rs_ready   = rst_n && (count < CNT_FULL);
  assign bus.q_count    = count;
  assign bus.pred_valid = pred_valid_q;
  assign bus.pred_idx   = pred_idx_q;
  assign bus.pred_taken = pred_taken_q;

  assign head_idx = fifo_idx[rd_ptr];
  assign head_tkn = fifo_tkn[rd_ptr];
  assign head_ctr = tbl[head_idx];

  always_comb begin
    new_ctr = head_ctr;
    if (head_tkn) begin
      if (head_ctr != 2'b11) new_ctr = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) new_ctr = head_ctr - 2'b01;
    end
  end

  // Queue payload needs no reset: only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_idx[wr_ptr] <= bus.rs_idx;
      fifo_tkn[wr_ptr] <= bus.rs_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_ENT; i++) tbl[i] <= INIT_CTR;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      defer        <= '0;
      pred_valid_q <= 1'b0;
      pred_idx_q   <= '0;
      pred_taken_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr         <= rd_ptr + 1'b1;
        tbl[head_idx]  <= new_ctr;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Defer counts only lookups that won against a non-empty queue.
      if (pop || count == '0) begin
        defer <= '0;
      end else if (lk_grant && defer != DEF_MAX) begin
        defer <= defer + 1'b1;
      end
      pred_valid_q <= lk_grant;
      if (lk_grant) begin
        pred_idx_q   <= bus.lk_idx;
        pred_taken_q <= tbl[bus.lk_idx][1];
      end
    end
  end
endmodule
